csr_access_ctrl: RTL

- Sequences one CSR instruction at a time from the core onto the CSR bus. The CSR bus is a combinational mux to the PMP and AIA register files.
- Upstream: valid/ready request channel and valid/ready completion channel.
- Holds the access on the bus until the target responds. Converts unmapped or silent targets into a timeout exception.
- Handles pipeline flush without aborting a bus access that has already started.

---
 rtl/csr_ctrl_pkg.sv | 19 +
 rtl/csr_access_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/csr_ctrl_pkg.sv
// Shared types and constants for the CSR access controller.
package csr_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [1:0] CauseNone    = 2'd0;
  localparam logic [1:0] CauseTarget  = 2'd1;
  localparam logic [1:0] CauseTimeout = 2'd2;
  localparam logic [1:0] CauseIllegal = 2'd3;

  // Bit positions inside req_op / csr_op.
  localparam int unsigned CsrOpR = 1;
  localparam int unsigned CsrOpW = 0;

endpackage

// File: rtl/csr_access_ctrl.sv
// Sequences one CSR instruction at a time onto the combinational CSR bus, with
// timeout detection and flush handling that never tears an in-flight access.
module csr_access_ctrl
  import csr_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [2:0]            req_funct3,
  input  logic [4:0]            req_imm,
  input  logic [REG_WIDTH-1:0]  req_rs1_val,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [4:0]            req_rd,
  input  logic                  flush,
  output logic                  cpl_valid,
  input  logic                  cpl_ready,
  output logic [ADDR_WIDTH-1:0] cpl_rdata,
  output logic [4:0]            cpl_rd,
  output logic                  cpl_exc,
  output logic [1:0]            cpl_cause,
  output logic [1:0]            csr_op,
  output logic [2:0]            csr_funct3,
  output logic [4:0]            csr_imm,
  output logic [REG_WIDTH-1:0]  rs1_val,
  output logic [ADDR_WIDTH-1:0] csr_addr,
  output logic                  csr_valid,
  output logic                  csr_rrsp,
  input  logic [ADDR_WIDTH-1:0] csr_rdata,
  input  logic                  csr_rvalid,
  input  logic                  csr_reg_rsp
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [4:0]            imm_q, imm_d;
  logic [REG_WIDTH-1:0]  rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [4:0]            rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] rdata_q, rdata_d;
  logic                  exc_q, exc_d;
  logic [1:0]            cause_q, cause_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  flush_pend_q, flush_pend_d;

  logic in_req;
  logic in_done;

  assign in_req  = (state_q == StReq);
  assign in_done = (state_q == StDone);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    funct3_d     = funct3_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    rdata_d      = rdata_q;
    exc_d        = exc_q;
    cause_d      = cause_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d     = req_op;
          funct3_d = req_funct3;
          imm_d    = req_imm;
          rs1_d    = req_rs1_val;
          addr_d   = req_addr;
          rd_d     = req_rd;
          cnt_d    = '0;
          if (!req_op[CsrOpR] && !req_op[CsrOpW]) begin
            exc_d   = 1'b1;
            cause_d = CauseIllegal;
            rdata_d = '0;
            state_d = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end

      StReq: begin
        // The access keeps running after a flush; only its result is dropped.
        if (flush) flush_pend_d = 1'b1;
        if (csr_rvalid) begin
          rdata_d = csr_reg_rsp ? '0 : csr_rdata;
          exc_d   = csr_reg_rsp;
          cause_d = csr_reg_rsp ? CauseTarget : CauseNone;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          exc_d   = 1'b1;
          cause_d = CauseTimeout;
          state_d = StDone;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        if (flush_pend_q || cpl_ready || flush) begin
          state_d      = StIdle;
          op_d         = '0;
          funct3_d     = '0;
          imm_d        = '0;
          rs1_d        = '0;
          addr_d       = '0;
          rd_d         = '0;
          rdata_d      = '0;
          exc_d        = 1'b0;
          cause_d      = CauseNone;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      funct3_q     <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      addr_q       <= '0;
      rd_q         <= '0;
      rdata_q      <= '0;
      exc_q        <= 1'b0;
      cause_q      <= CauseNone;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      funct3_q     <= funct3_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      rdata_q      <= rdata_d;
      exc_q        <= exc_d;
      cause_q      <= cause_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign req_ready  = (state_q == StIdle);

  assign csr_valid  = in_req;
  assign csr_rrsp   = in_req;
  assign csr_op     = in_req ? op_q     : '0;
  assign csr_funct3 = in_req ? funct3_q : '0;
  assign csr_imm    = in_req ? imm_q    : '0;
  assign rs1_val    = in_req ? rs1_q    : '0;
  assign csr_addr   = in_req ? addr_q   : '0;

  assign cpl_valid  = in_done && !flush_pend_q;
  assign cpl_rdata  = cpl_valid ? rdata_q : '0;
  assign cpl_rd     = cpl_valid ? rd_q    : '0;
  assign cpl_exc    = cpl_valid ? exc_q   : 1'b0;
  assign cpl_cause  = cpl_valid ? cause_q : CauseNone;

endmodule
